// File: rtl/write_back_unit.sv
// Write-back stage: retires ALU results and formats loads into the register file.
// Registered forwarding copy of the write port and a retired-instruction counter.
module write_back_unit #(
  parameter int XLEN    = 32,
  parameter int RADDR_W = 5
) (
  input  logic               Clock,
  input  logic               nReset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               Wreg,
  input  logic               Rmem,
  input  logic [RADDR_W-1:0] rd,
  input  logic [XLEN-1:0]    result,
  input  logic [2:0]         funct3,
  input  logic [2:0]         addr_lo,
  input  logic               flush,
  input  logic               mem_rvalid,
  input  logic [XLEN-1:0]    mem_rdata,
  output logic               rf_we,
  output logic [RADDR_W-1:0] rf_rd,
  output logic [XLEN-1:0]    rf_wdata,
  output logic               fwd_valid,
  output logic [RADDR_W-1:0] fwd_rd,
  output logic [XLEN-1:0]    fwd_data,
  output logic [31:0]        retired
);

  localparam logic [0:0] IDLE     = 1'b0;
  localparam logic [0:0] WAIT_MEM = 1'b1;

  localparam bit         IS64     = (XLEN == 64);
  localparam logic [2:0] OFF_MASK = IS64 ? 3'b111 : 3'b011;

  logic [0:0]         state_q, state_d;
  logic [RADDR_W-1:0] rd_q, rd_d;
  logic               wreg_q, wreg_d;
  logic [2:0]         funct3_q, funct3_d;
  logic [2:0]         addr_lo_q, addr_lo_d;
  logic               fwd_valid_q, fwd_valid_d;
  logic [RADDR_W-1:0] fwd_rd_q, fwd_rd_d;
  logic [XLEN-1:0]    fwd_data_q, fwd_data_d;
  logic [31:0]        retired_q, retired_d;

  logic [2:0]      sel_f3;
  logic [2:0]      sel_off;
  logic [XLEN-1:0] b_sh, h_sh, w_sh;
  logic [XLEN-1:0] fmt;
  logic            done;

  // A pending load is formatted with the fields captured at acceptance.
  always_comb begin
    sel_f3  = (state_q == WAIT_MEM) ? funct3_q : funct3;
    sel_off = ((state_q == WAIT_MEM) ? addr_lo_q : addr_lo) & OFF_MASK;
    b_sh    = mem_rdata >> {sel_off, 3'b000};
    h_sh    = mem_rdata >> {sel_off[2:1], 4'b0000};
    w_sh    = mem_rdata >> {sel_off[2], 5'b00000};
    fmt     = mem_rdata;
    unique case (1'b1)
      (sel_f3 == 3'b000): begin
        fmt      = {XLEN{b_sh[7]}};
        fmt[7:0] = b_sh[7:0];
      end
      (sel_f3 == 3'b100): begin
        fmt      = '0;
        fmt[7:0] = b_sh[7:0];
      end
      (sel_f3 == 3'b001): begin
        fmt       = {XLEN{h_sh[15]}};
        fmt[15:0] = h_sh[15:0];
      end
      (sel_f3 == 3'b101): begin
        fmt       = '0;
        fmt[15:0] = h_sh[15:0];
      end
      (sel_f3 == 3'b010): begin
        fmt       = {XLEN{w_sh[31]}};
        fmt[31:0] = w_sh[31:0];
      end
      (sel_f3 == 3'b110 && IS64): begin
        fmt       = '0;
        fmt[31:0] = w_sh[31:0];
      end
      default: fmt = mem_rdata;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    rd_d      = rd_q;
    wreg_d    = wreg_q;
    funct3_d  = funct3_q;
    addr_lo_d = addr_lo_q;
    rf_we     = 1'b0;
    rf_rd     = '0;
    rf_wdata  = '0;
    done      = 1'b0;
    in_ready  = nReset && (state_q == IDLE);
    if (nReset) begin
      unique case (1'b1)
        (state_q == IDLE): begin
          if (in_valid && !Rmem) begin
            done     = 1'b1;
            rf_we    = Wreg && (rd != '0);
            rf_rd    = rd;
            rf_wdata = result;
          end else if (in_valid && mem_rvalid) begin
            done     = 1'b1;
            rf_we    = Wreg && (rd != '0);
            rf_rd    = rd;
            rf_wdata = fmt;
          end else if (in_valid) begin
            rd_d      = rd;
            wreg_d    = Wreg;
            funct3_d  = funct3;
            addr_lo_d = addr_lo;
            state_d   = WAIT_MEM;
          end
        end
        (state_q == WAIT_MEM): begin
          if (flush) begin
            state_d = IDLE;
          end else if (mem_rvalid) begin
            done     = 1'b1;
            rf_we    = wreg_q && (rd_q != '0);
            rf_rd    = rd_q;
            rf_wdata = fmt;
            state_d  = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    fwd_valid_d = rf_we;
    fwd_rd_d    = rf_rd;
    fwd_data_d  = rf_wdata;
    retired_d   = retired_q + {31'd0, done};
  end

  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      state_q     <= IDLE;
      rd_q        <= '0;
      wreg_q      <= 1'b0;
      funct3_q    <= '0;
      addr_lo_q   <= '0;
      fwd_valid_q <= 1'b0;
      fwd_rd_q    <= '0;
      fwd_data_q  <= '0;
      retired_q   <= '0;
    end else begin
      state_q     <= state_d;
      rd_q        <= rd_d;
      wreg_q      <= wreg_d;
      funct3_q    <= funct3_d;
      addr_lo_q   <= addr_lo_d;
      fwd_valid_q <= fwd_valid_d;
      fwd_rd_q    <= fwd_rd_d;
      fwd_data_q  <= fwd_data_d;
      retired_q   <= retired_d;
    end
  end

  assign fwd_valid = fwd_valid_q;
  assign fwd_rd    = fwd_rd_q;
  assign fwd_data  = fwd_data_q;
  assign retired   = retired_q;

endmodule
